// File: rtl/if_fetch_unit.sv
// ----------------------------------------------------------------------------
// if_fetch_unit
//   Instruction-fetch stage feeding the IF/ID register. Owns the PC, keeps at
//   most one instruction-memory read in flight, and presents pc/instruction
//   together with im_stall. Redirects come from EX (branch/jump) and from the
//   CSR unit (trap entry / mret). CSR redirects win over EX redirects, and any
//   redirect wins over a normal advance.
//
// Ports
//   clk, reset          clock (rising edge), async active-low reset
//   IFID_write          hazard-unit enable for IF/ID (0 = hold)
//   dm_stall            data-memory stall, freezes presentation
//   branch_taken        EX redirect request, target in branch_target
//   CSR_interrupt       trap-entry redirect, target in csr_target
//   CSR_ret             mret redirect, target in csr_target
//   im_req/im_addr      IM read request / word-aligned address
//   im_ready            IM accepts the request this cycle
//   im_rvalid/im_rdata  IM read response
//   pc/instruction      presented fetch pair
//   im_stall            1 = no valid instruction presented, IF/ID must hold
// ----------------------------------------------------------------------------
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        IFID_write,
    input  logic        dm_stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        CSR_interrupt,
    input  logic        CSR_ret,
    input  logic [31:0] csr_target,
    output logic        im_req,
    output logic [31:0] im_addr,
    input  logic        im_ready,
    input  logic        im_rvalid,
    input  logic [31:0] im_rdata,
    output logic [31:0] pc,
    output logic [31:0] instruction,
    output logic        im_stall
);

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] PC_STEP    = XLEN'(4);
    localparam logic [XLEN-1:0] RESET_ADDR = {RESET_PC[XLEN-1:2], 2'b00};

    typedef enum logic [1:0] {
        ST_REQ   = 2'd0,
        ST_WAIT  = 2'd1,
        ST_READY = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [XLEN-1:0]   req_addr_q, req_addr_d;
    logic [XLEN-1:0]   inst_q, inst_d;
    logic              kill_q, kill_d;
    logic              im_req_q, im_req_d;
    logic              im_stall_q, im_stall_d;

    logic              csr_redir;
    logic              redir;
    logic              advance;
    logic [XLEN-1:0]   tgt;
    logic [XLEN-1:0]   tgt_aligned;

    // Redirect selection and IF/ID advance qualification
    always_comb begin
        csr_redir   = CSR_interrupt | CSR_ret;
        redir       = csr_redir | branch_taken;
        tgt         = csr_redir ? csr_target : branch_target;
        tgt_aligned = {tgt[XLEN-1:2], 2'b00};
        advance     = IFID_write & ~im_stall_q & ~dm_stall;
    end

    // State register; im_req is low during reset and the first cycle after it
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_REQ;
            pc_q       <= RESET_PC;
            req_addr_q <= RESET_ADDR;
            inst_q     <= '0;
            kill_q     <= 1'b0;
            im_req_q   <= 1'b0;
            im_stall_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_addr_q <= req_addr_d;
            inst_q     <= inst_d;
            kill_q     <= kill_d;
            im_req_q   <= im_req_d;
            im_stall_q <= im_stall_d;
        end
    end

    // Next-state and registered-output computation
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_addr_d = req_addr_q;
        inst_d     = inst_q;
        kill_d     = kill_q;

        unique case (state_q)
            ST_REQ: begin
                // The pending request keeps its old address; a redirect only
                // marks the eventual response as stale.
                if (redir) begin
                    pc_d   = tgt;
                    kill_d = 1'b1;
                end
                if (im_req_q && im_ready) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (redir) begin
                    pc_d   = tgt;
                    kill_d = 1'b1;
                end
                if (im_rvalid) begin
                    // A redirect arriving together with the data also kills it
                    if (kill_q || redir) begin
                        kill_d     = 1'b0;
                        req_addr_d = {pc_d[XLEN-1:2], 2'b00};
                        state_d    = ST_REQ;
                    end else begin
                        inst_d  = im_rdata;
                        state_d = ST_READY;
                    end
                end
            end
            ST_READY: begin
                if (redir) begin
                    pc_d       = tgt;
                    req_addr_d = tgt_aligned;
                    state_d    = ST_REQ;
                end else if (advance) begin
                    pc_d       = pc_q + PC_STEP;
                    req_addr_d = {pc_d[XLEN-1:2], 2'b00};
                    state_d    = ST_REQ;
                end
            end
            default: begin
                state_d = ST_REQ;
            end
        endcase

        im_req_d   = (state_d == ST_REQ);
        im_stall_d = (state_d != ST_READY) | kill_d;
    end

    assign im_req      = im_req_q;
    assign im_addr     = req_addr_q;
    assign pc          = pc_q;
    assign instruction = inst_q;
    assign im_stall    = im_stall_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// ----------------------------------------------------------------------------
// tb_if_fetch_unit
//   Self-checking bench for if_fetch_unit. A transaction-level model tracks
//   the architectural PC the stage must present (redirect, else +4 on
//   advance) and a memory model answers requests with random latency, using
//   a fixed address-to-data function so every presented instruction can be
//   predicted from its PC.
// ----------------------------------------------------------------------------
module tb_if_fetch_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        IFID_write = 1'b0;
    logic        dm_stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = '0;
    logic        CSR_interrupt = 1'b0;
    logic        CSR_ret = 1'b0;
    logic [31:0] csr_target = '0;
    logic        im_req;
    logic [31:0] im_addr;
    logic        im_ready = 1'b0;
    logic        im_rvalid = 1'b0;
    logic [31:0] im_rdata = '0;
    logic [31:0] pc;
    logic [31:0] instruction;
    logic        im_stall;

    if_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk           (clk),
        .reset         (reset),
        .IFID_write    (IFID_write),
        .dm_stall      (dm_stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .CSR_interrupt (CSR_interrupt),
        .CSR_ret       (CSR_ret),
        .csr_target    (csr_target),
        .im_req        (im_req),
        .im_addr       (im_addr),
        .im_ready      (im_ready),
        .im_rvalid     (im_rvalid),
        .im_rdata      (im_rdata),
        .pc            (pc),
        .instruction   (instruction),
        .im_stall      (im_stall)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
        end
    endtask

    // Instruction memory contents as a pure function of the word address
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] w;
        w = {a[31:2], 2'b00};
        if (w == 32'h0) return 32'h0000_0013;
        return (w * 32'h9E37_79B1) ^ 32'hC0DE_0000;
    endfunction

    // Stimulus knobs for the pipeline side
    logic        d_ifid = 1'b1;
    logic        d_dm = 1'b0;
    logic        d_br = 1'b0;
    logic        d_ci = 1'b0;
    logic        d_cr = 1'b0;
    logic [31:0] d_bt = '0;
    logic [31:0] d_ct = '0;
    int          rdy_mode = 1;   // 0 random, 1 always, 2 never
    int          lat_min = 0;
    int          lat_max = 0;
    logic        spur_en = 1'b0;

    // Reference model and memory state
    logic [31:0] exp_pc = '0;
    logic        mem_pend = 1'b0;
    int          mem_cnt = 0;
    logic [31:0] mem_addr = '0;
    logic        prev_req = 1'b0;
    logic        prev_acc = 1'b0;
    logic [31:0] prev_addr = '0;
    int          idle = 0;
    int          cyc = 0;

    // Samples from the latest step
    logic        s_stall;
    logic        s_req;
    logic [31:0] s_pc;
    logic [31:0] s_addr;
    logic [31:0] s_instr;
    logic        s_acc;
    logic [31:0] s_acc_addr;

    // One clock: sample and check outputs, then drive inputs for the next edge
    task automatic step();
        logic acc;
        logic redir;
        @(negedge clk);
        cyc++;
        s_stall = im_stall;
        s_req   = im_req;
        s_pc    = pc;
        s_addr  = im_addr;
        s_instr = instruction;

        check("pc", pc, exp_pc);
        if (!im_stall) begin
            check("instr", instruction, mem_word(exp_pc));
            idle = 0;
        end else begin
            idle++;
        end
        if (idle > 200) begin
            check("liveness", 32'(idle), 32'd0);
            idle = 0;
        end
        if (im_req) begin
            check("one_outstanding", 32'(mem_pend), 32'd0);
            if (prev_req && !prev_acc) check("addr_hold", im_addr, prev_addr);
            else                       check("req_addr", im_addr, {exp_pc[31:2], 2'b00});
        end

        im_rvalid = 1'b0;
        im_rdata  = $urandom;
        if (mem_pend) begin
            if (mem_cnt == 0) begin
                im_rvalid = 1'b1;
                im_rdata  = mem_word(mem_addr);
                mem_pend  = 1'b0;
            end else begin
                mem_cnt--;
            end
        end else if (spur_en && $urandom_range(0, 7) == 0) begin
            im_rvalid = 1'b1;
        end

        case (rdy_mode)
            0:       im_ready = 1'($urandom_range(0, 1));
            1:       im_ready = 1'b1;
            default: im_ready = 1'b0;
        endcase
        acc = im_req && im_ready;
        if (acc) begin
            mem_pend = 1'b1;
            mem_cnt  = int'($urandom_range(lat_max, lat_min));
            mem_addr = im_addr;
        end
        s_acc      = acc;
        s_acc_addr = im_addr;
        prev_req   = im_req;
        prev_acc   = acc;
        prev_addr  = im_addr;

        IFID_write    = d_ifid;
        dm_stall      = d_dm;
        branch_taken  = d_br;
        branch_target = d_bt;
        CSR_interrupt = d_ci;
        CSR_ret       = d_cr;
        csr_target    = d_ct;

        redir = d_ci | d_cr | d_br;
        if (redir)                                exp_pc = (d_ci | d_cr) ? d_ct : d_bt;
        else if (d_ifid && !im_stall && !d_dm)    exp_pc = exp_pc + 32'd4;
    endtask

    task automatic clear_redir();
        d_br = 1'b0;
        d_ci = 1'b0;
        d_cr = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b0;
        IFID_write = 1'b0; dm_stall = 1'b0; branch_taken = 1'b0;
        CSR_interrupt = 1'b0; CSR_ret = 1'b0; im_ready = 1'b0; im_rvalid = 1'b0;
        clear_redir();
        d_dm = 1'b0;
        #2;
        check("rst_im_req", 32'(im_req), 32'd0);
        check("rst_pc", pc, 32'h0);
        check("rst_instr", instruction, 32'h0);
        check("rst_im_stall", 32'(im_stall), 32'd1);
        exp_pc = 32'h0; mem_pend = 1'b0; prev_req = 1'b0; prev_acc = 1'b0; idle = 0;
        @(negedge clk);
        reset     = 1'b1;
        // Stale response right at release must be ignored
        im_rvalid = 1'b1;
        im_rdata  = 32'hDEAD_BEEF;
    endtask

    task automatic wait_pres(input string tag);
        for (int i = 0; i < 100; i++) begin
            step();
            if (!s_stall) return;
        end
        check(tag, 32'(s_stall), 32'd0);
    endtask

    initial begin
        int last;
        int npres;
        logic [31:0] held;

        // Reset, first fetch and sequential stream with fixed 1-cycle latency
        apply_reset();
        rdy_mode = 1; lat_min = 0; lat_max = 0; d_ifid = 1'b1;
        last = 0; npres = 0;
        for (int i = 0; i < 40 && npres < 4; i++) begin
            step();
            if (!s_stall) begin
                if (npres == 0) check("first_instr", s_instr, 32'h0000_0013);
                else            check("seq_gap", 32'(cyc - last), 32'd3);
                check("seq_pc", s_pc, 32'(4 * npres));
                last = cyc;
                npres++;
            end
        end
        check("seq_count", 32'(npres), 32'd4);

        // Branch while waiting for the word at 8
        apply_reset();
        lat_min = 2; lat_max = 2; d_ifid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            step();
            if (s_acc && s_acc_addr == 32'h8) break;
        end
        d_br = 1'b1; d_bt = 32'h100;
        step();
        clear_redir();
        wait_pres("br_timeout");
        check("br_pc", s_pc, 32'h100);
        check("br_instr", s_instr, mem_word(32'h100));

        // CSR and branch redirect together from READY: CSR wins
        lat_min = 0; lat_max = 0; d_ifid = 1'b0;
        wait_pres("csr_wait_timeout");
        d_ci = 1'b1; d_br = 1'b1; d_ct = 32'h200; d_bt = 32'h100;
        step();
        clear_redir();
        wait_pres("csr_timeout");
        check("csr_pc", s_pc, 32'h200);

        // dm_stall holds the presented pair at pc=4
        apply_reset();
        d_ifid = 1'b1;
        wait_pres("dm_t0");
        d_ifid = 1'b0;
        wait_pres("dm_t1");
        check("dm_start_pc", s_pc, 32'h4);
        d_dm = 1'b1; d_ifid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("dm_hold_stall", 32'(s_stall), 32'd0);
            check("dm_hold_pc", s_pc, 32'h4);
        end
        d_dm = 1'b0;
        step();
        wait_pres("dm_resume");
        check("dm_resume_pc", s_pc, 32'h8);

        // IM not ready for 4 cycles, redirect to 0x40 in the middle
        d_ifid = 1'b0;
        wait_pres("t6_wait");
        held = s_pc + 32'd4;
        rdy_mode = 2; d_ifid = 1'b1;
        step();
        for (int k = 1; k <= 4; k++) begin
            if (k == 2) begin d_br = 1'b1; d_bt = 32'h40; end
            step();
            clear_redir();
            check("t6_req", 32'(s_req), 32'd1);
            check("t6_addr", s_addr, {held[31:2], 2'b00});
        end
        rdy_mode = 1; d_ifid = 1'b0;
        wait_pres("t6_timeout");
        check("t6_pc", s_pc, 32'h40);

        // PC wraps modulo 2^32
        d_br = 1'b1; d_bt = 32'hFFFF_FFFC;
        step();
        clear_redir();
        d_ifid = 1'b1;
        wait_pres("wrap_t0");
        check("wrap_pc_hi", s_pc, 32'hFFFF_FFFC);
        wait_pres("wrap_t1");
        check("wrap_pc_lo", s_pc, 32'h0);

        // Randomized traffic with random IM timing, stalls and redirects
        rdy_mode = 0; lat_min = 0; lat_max = 3; spur_en = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) apply_reset();
            d_ifid = ($urandom_range(0, 3) != 0);
            d_dm   = ($urandom_range(0, 4) == 0);
            clear_redir();
            if ($urandom_range(0, 24) == 0) begin
                case ($urandom_range(0, 3))
                    0:       d_br = 1'b1;
                    1:       d_ci = 1'b1;
                    2:       d_cr = 1'b1;
                    default: begin d_br = 1'b1; d_cr = 1'b1; end
                endcase
                d_bt = 32'($urandom_range(0, 255)) << 2;
                d_ct = 32'($urandom_range(256, 511)) << 2;
                if ($urandom_range(0, 7) == 0) d_bt = 32'hFFFF_FFF8;
                if ($urandom_range(0, 7) == 0) d_ct = d_ct | 32'($urandom_range(1, 3));
            end
            step();
        end
        clear_redir();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
